// File: rtl/pcs_sync_pkg.sv
// PCS code-group synchronization: shared state encoding,
// default parameters and state-step helpers.
package pcs_sync_pkg;

    localparam int unsigned SLIP_TIMEOUT_DEF = 20;
    localparam int unsigned GOOD_CGS_DEF     = 4;

    typedef enum logic [3:0] {
        ST_LOSS,
        ST_CD1,
        ST_AS1,
        ST_CD2,
        ST_AS2,
        ST_CD3,
        ST_SA1,
        ST_SA2,
        ST_SA3,
        ST_SA4
    } sync_st_t;

    function automatic logic in_sync(sync_st_t s);
        return (s == ST_SA1) || (s == ST_SA2) ||
               (s == ST_SA3) || (s == ST_SA4);
    endfunction

    // One step further from sync; SA4 falls back to LOSS
    function automatic sync_st_t sa_down(sync_st_t s);
        unique case (s)
            ST_SA1:  return ST_SA2;
            ST_SA2:  return ST_SA3;
            ST_SA3:  return ST_SA4;
            default: return ST_LOSS;
        endcase
    endfunction

    // One step back towards full sync
    function automatic sync_st_t sa_up(sync_st_t s);
        unique case (s)
            ST_SA4:  return ST_SA3;
            ST_SA3:  return ST_SA2;
            default: return ST_SA1;
        endcase
    endfunction

endpackage

// File: rtl/pcs_sync_fsm_if.sv
// Decoder-side bundle of the PCS sync FSM: code-group flags in,
// sync status, disparity override, slip and error count out.
interface pcs_sync_fsm_if;

    logic        i_Valid;
    logic        i_Kout;
    logic        i_DErr;
    logic        i_KErr;
    logic        i_DpErr;
    logic        i_Comma;
    logic        i_ErrCntClr;
    logic        o_SyncStatus;
    logic        o_ForceDisparity;
    logic        o_Disparity;
    logic        o_SlipReq;
    logic        o_RxEven;
    logic [15:0] o16_ErrCnt;

    modport master (
        output i_Valid, i_Kout, i_DErr, i_KErr, i_DpErr,
        output i_Comma, i_ErrCntClr,
        input  o_SyncStatus, o_ForceDisparity, o_Disparity,
        input  o_SlipReq, o_RxEven, o16_ErrCnt
    );

    modport slave (
        input  i_Valid, i_Kout, i_DErr, i_KErr, i_DpErr,
        input  i_Comma, i_ErrCntClr,
        output o_SyncStatus, o_ForceDisparity, o_Disparity,
        output o_SlipReq, o_RxEven, o16_ErrCnt
    );

endinterface

// File: rtl/pcs_sat_cnt.sv
// Saturating up-counter with synchronous clear;
// clear takes priority over increment.
module pcs_sat_cnt #(
    parameter int unsigned pW = 16
) (
    input  logic          i_Clk,
    input  logic          i_ARst_L,
    input  logic          i_Inc,
    input  logic          i_Clr,
    output logic [pW-1:0] o_Cnt
);

    // Count up, stick at all-ones, clear on demand
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            o_Cnt <= '0;
        end else if (i_Clr) begin
            o_Cnt <= '0;
        end else if (i_Inc && (o_Cnt != '1)) begin
            o_Cnt <= o_Cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pcs_sync_fsm.sv
// PCS receive synchronization FSM with comma-slip timeout.
// Define PCS_SYNC_ERRCNT_EN to enable the bad code-group counter.
module pcs_sync_fsm
    import pcs_sync_pkg::*;
#(
    parameter int unsigned pSLIP_TIMEOUT = SLIP_TIMEOUT_DEF,
    parameter int unsigned pGOOD_CGS     = GOOD_CGS_DEF
) (
    input  logic          i_Clk,
    input  logic          i_ARst_L,
    pcs_sync_fsm_if.slave bus
);

    localparam int unsigned SW = $clog2(pSLIP_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(pGOOD_CGS + 1);
    localparam logic [SW-1:0] SLIP_LAST = SW'(pSLIP_TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(pGOOD_CGS - 1);

    sync_st_t      state_q, state_d;
    logic [SW-1:0] slip_q, slip_d;
    logic [GW-1:0] good_q, good_d;
    logic          even_q, even_d;
    logic          slip_req_d, slip_req_q;
    logic          sync_d, sync_q;
    logic          force_d, force_q;
    logic          cgbad, cggood;

    assign cgbad  = bus.i_DErr | bus.i_KErr | bus.i_DpErr |
                    (bus.i_Comma & even_q);
    assign cggood = ~cgbad;

    // State, counters and even/odd tracker
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state_q <= ST_LOSS;
            slip_q  <= '0;
            good_q  <= '0;
            even_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
            good_q  <= good_d;
            even_q  <= even_d;
        end
    end

    // Next state; everything holds on cycles without a code-group
    always_comb begin
        state_d    = state_q;
        slip_d     = slip_q;
        good_d     = good_q;
        even_d     = even_q;
        slip_req_d = 1'b0;
        if (bus.i_Valid) begin
            even_d = ~even_q;
            unique case (state_q)
                ST_LOSS: begin
                    if (bus.i_Comma) begin
                        state_d = ST_CD1;
                        even_d  = 1'b1;
                    end else if (slip_q >= SLIP_LAST) begin
                        slip_req_d = 1'b1;
                        slip_d     = '0;
                    end else begin
                        slip_d = slip_q + 1'b1;
                    end
                end
                ST_CD1: state_d = (cggood & ~bus.i_Kout) ? ST_AS1 : ST_LOSS;
                ST_CD2: state_d = (cggood & ~bus.i_Kout) ? ST_AS2 : ST_LOSS;
                ST_CD3: state_d = (cggood & ~bus.i_Kout) ? ST_SA1 : ST_LOSS;
                ST_AS1, ST_AS2: begin
                    if (cgbad) begin
                        state_d = ST_LOSS;
                    end else if (bus.i_Comma) begin
                        state_d = (state_q == ST_AS1) ? ST_CD2 : ST_CD3;
                        even_d  = 1'b1;
                    end
                end
                ST_SA1: begin
                    if (cgbad) begin
                        state_d = ST_SA2;
                        good_d  = '0;
                    end
                end
                ST_SA2, ST_SA3, ST_SA4: begin
                    if (cgbad) begin
                        state_d = sa_down(state_q);
                        good_d  = '0;
                    end else if (good_q >= GOOD_LAST) begin
                        state_d = sa_up(state_q);
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                default: state_d = ST_LOSS;
            endcase
            // Slip count lives only in LOSS, good count only in SA2..SA4
            if (state_d != ST_LOSS) slip_d = '0;
            if (!in_sync(state_d))  good_d = '0;
        end
    end

    // Status decode from the current state
    always_comb begin
        sync_d  = in_sync(state_q);
        force_d = ~sync_d;
    end

    // Registered outputs
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            sync_q     <= 1'b0;
            force_q    <= 1'b1;
            slip_req_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            force_q    <= force_d;
            slip_req_q <= slip_req_d;
        end
    end

    assign bus.o_SyncStatus     = sync_q;
    assign bus.o_ForceDisparity = force_q;
    assign bus.o_Disparity      = force_q;
    assign bus.o_SlipReq        = slip_req_q;
    assign bus.o_RxEven         = even_q;

`ifdef PCS_SYNC_ERRCNT_EN
    logic err_inc;
    assign err_inc = bus.i_Valid & cgbad & sync_q;

    pcs_sat_cnt #(
        .pW (16)
    ) u_err_cnt (
        .i_Clk    (i_Clk),
        .i_ARst_L (i_ARst_L),
        .i_Inc    (err_inc),
        .i_Clr    (bus.i_ErrCntClr),
        .o_Cnt    (bus.o16_ErrCnt)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.i_ErrCntClr;
    assign bus.o16_ErrCnt  = '0;
`endif

endmodule

// File: tb/tb_pcs_sync_fsm.sv
// Scoreboard bench for pcs_sync_fsm: directed code-group
// sequences push expected outputs, a monitor compares them.
module tb_pcs_sync_fsm;

    logic i_Clk    = 1'b0;
    logic i_ARst_L = 1'b0;

    always #5 i_Clk = ~i_Clk;

    pcs_sync_fsm_if bus ();

    pcs_sync_fsm #(
        .pSLIP_TIMEOUT (20),
        .pGOOD_CGS     (4)
    ) dut (
        .i_Clk    (i_Clk),
        .i_ARst_L (i_ARst_L),
        .bus      (bus)
    );

    typedef struct {
        int due;
        int sy;
        int fd;
        int sl;
        int ev;
        int ec;
    } exp_t;

    exp_t  sbq[$];
    string nmq[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_fail = 0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    function automatic int ecx(int v);
`ifdef PCS_SYNC_ERRCNT_EN
        return v;
`else
        return (v < 0) ? v : 0;
`endif
    endfunction

    task automatic chk(input string nm, input string f,
                       input int act, input int ex);
        n_chk++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, want %0d", nm, f, act, ex);
        end
    endtask

    task automatic check_one(input exp_t e, input string nm);
        if (e.sy >= 0) chk(nm, "sync", int'(bus.o_SyncStatus), e.sy);
        if (e.fd >= 0) chk(nm, "force", int'(bus.o_ForceDisparity), e.fd);
        if (e.fd == 1) chk(nm, "disp", int'(bus.o_Disparity), 1);
        if (e.sl >= 0) chk(nm, "slip", int'(bus.o_SlipReq), e.sl);
        if (e.ev >= 0) chk(nm, "even", int'(bus.o_RxEven), e.ev);
        if (e.ec >= 0) chk(nm, "errcnt", int'(bus.o16_ErrCnt), e.ec);
    endtask

    // Clocked monitor: compare entries due at this cycle
    always @(negedge i_Clk) begin
        while (sbq.size() > 0 && sbq[0].due >= 0 && sbq[0].due <= cyc) begin
            if (sbq[0].due != cyc) chk(nmq[0], "slot", cyc, sbq[0].due);
            check_one(sbq[0], nmq[0]);
            sbq.delete(0);
            nmq.delete(0);
        end
    end

    // Reset monitor: compare entries tagged for the reset edge
    always @(negedge i_ARst_L) begin
        #1;
        if (sbq.size() > 0 && sbq[0].due == -1) begin
            check_one(sbq[0], nmq[0]);
            sbq.delete(0);
            nmq.delete(0);
        end
    end

    task automatic push(input int due, input int sy, input int fd,
                        input int sl, input int ev, input int ec,
                        input string nm);
        exp_t e;
        e.due = due; e.sy = sy; e.fd = fd;
        e.sl  = sl;  e.ev = ev; e.ec = ec;
        sbq.push_back(e);
        nmq.push_back(nm);
    endtask

    task automatic cg(input bit v, input bit k, input bit de,
                      input bit ke, input bit dpe, input bit cm,
                      input bit clr, input int sy, input int fd,
                      input int sl, input int ev, input int ec,
                      input string nm);
        @(posedge i_Clk);
        #1;
        bus.i_Valid     = v;
        bus.i_Kout      = k;
        bus.i_DErr      = de;
        bus.i_KErr      = ke;
        bus.i_DpErr     = dpe;
        bus.i_Comma     = cm;
        bus.i_ErrCntClr = clr;
        push(cyc + 1, sy, fd, sl, ev, ec, nm);
    endtask

    task automatic dat(input int sy, input int fd, input int sl,
                       input int ev, input int ec, input string nm);
        cg(1, 0, 0, 0, 0, 0, 0, sy, fd, sl, ev, ec, nm);
    endtask

    task automatic bad(input int sy, input int fd, input int sl,
                       input int ev, input int ec, input string nm);
        cg(1, 0, 1, 0, 0, 0, 0, sy, fd, sl, ev, ec, nm);
    endtask

    task automatic com(input int sy, input int fd, input int sl,
                       input int ev, input int ec, input string nm);
        cg(1, 1, 0, 0, 0, 1, 0, sy, fd, sl, ev, ec, nm);
    endtask

    task automatic idle(input int sy, input int fd, input int sl,
                        input int ev, input int ec, input string nm);
        cg(0, 0, 0, 0, 0, 0, 0, sy, fd, sl, ev, ec, nm);
    endtask

    // Comma/data pairs from LOSS; n=6 plus idle reaches sync
    task automatic acquire(input int n, input int ec, input string nm);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) com(0, 1, 0, 1, ec, nm);
            else            dat(0, 1, 0, 0, ec, nm);
        end
        if (n == 6) idle(1, 0, 0, 0, ec, nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
        push(-1, 0, 1, 0, 0, 0, nm);
        bus.i_Valid = 0; bus.i_Kout = 0; bus.i_DErr = 0;
        bus.i_KErr = 0; bus.i_DpErr = 0; bus.i_Comma = 0;
        bus.i_ErrCntClr = 0;
        i_ARst_L = 1'b0;
        idle(0, 1, 0, 0, 0, nm);
        idle(0, 1, 0, 0, 0, nm);
        i_ARst_L = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, want end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_Valid = 0; bus.i_Kout = 0; bus.i_DErr = 0;
        bus.i_KErr = 0; bus.i_DpErr = 0; bus.i_Comma = 0;
        bus.i_ErrCntClr = 0;

        // Reset state
        idle(0, 1, 0, 0, 0, "rst0");
        idle(0, 1, 0, 0, 0, "rst0");
        i_ARst_L = 1'b1;

        // Clean acquisition; sync one cycle after 6th code-group
        acquire(6, 0, "acq");

        // SA1: one error, four good -> back to SA1
        bad(1, 0, 0, 1, ecx(1), "sa1_err");
        dat(1, 0, 0, 0, ecx(1), "sa2_g1");
        dat(1, 0, 0, 1, ecx(1), "sa2_g2");
        dat(1, 0, 0, 0, ecx(1), "sa2_g3");
        dat(1, 0, 0, 1, ecx(1), "sa2_g4");

        // Four bad, interleaved with too few good -> LOSS
        bad(1, 0, 0, 0, ecx(2), "lose_b1");
        dat(1, 0, 0, 1, ecx(2), "lose_g1");
        bad(1, 0, 0, 0, ecx(3), "lose_b2");
        dat(1, 0, 0, 1, ecx(3), "lose_g2");
        dat(1, 0, 0, 0, ecx(3), "lose_g3");
        bad(1, 0, 0, 1, ecx(4), "lose_b3");
        dat(1, 0, 0, 0, ecx(4), "lose_g4");
        bad(1, 0, 0, 1, ecx(5), "lose_b4");
        idle(0, 1, 0, 1, ecx(5), "lost");

        // Slip timeout: pulses after the 20th and 40th
        for (int i = 1; i <= 40; i++)
            dat(0, 1, (i % 20 == 0) ? 1 : 0,
                (i % 2 == 0) ? 1 : 0, ecx(5), "slip");
        idle(0, 1, 0, 1, ecx(5), "slip_end");

        // Comma and leaving LOSS both restart the slip count
        for (int i = 1; i <= 10; i++)
            dat(0, 1, 0, (i % 2 == 0) ? 1 : 0, ecx(5), "pre");
        com(0, 1, 0, 1, ecx(5), "cd1");
        cg(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, ecx(5), "cd1_k");
        for (int i = 1; i <= 20; i++)
            dat(0, 1, (i == 20) ? 1 : 0, i % 2, ecx(5), "slip2");

        // Comma in CD1 -> LOSS, full reacquisition needed
        com(0, 1, 0, 1, ecx(5), "cd1b");
        com(0, 1, 0, 0, ecx(5), "cd1_comma");
        acquire(6, ecx(5), "reacq1");

        do_reset("rst_sa1");

        // Odd-position comma in AS1 -> LOSS
        com(0, 1, 0, 1, 0, "as1_c");
        dat(0, 1, 0, 0, 0, "as1_d");
        dat(0, 1, 0, 1, 0, "as1_d2");
        com(0, 1, 0, 0, 0, "as1_odd");
        acquire(6, 0, "reacq2");

        // Error counter: three bad, then clear with bad
        bad(1, 0, 0, 1, ecx(1), "ec1");
        bad(1, 0, 0, 0, ecx(2), "ec2");
        bad(1, 0, 0, 1, ecx(3), "ec3");
        cg(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, "ec_clr");
        idle(0, 1, 0, 0, 0, "ec_lost");

        // Reset mid-AS2: no slip, count restarts from zero
        acquire(4, 0, "to_as2");
        do_reset("rst_as2");
        for (int i = 1; i <= 20; i++)
            dat(0, 1, (i == 20) ? 1 : 0, i % 2, 0, "slip3");

        // Reset while synchronized
        acquire(6, 0, "reacq3");
        do_reset("rst_sync");

        repeat (3) @(posedge i_Clk);
        chk("drain", "left", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
